// File: rtl/mips_imem_pkg.sv
// ============================================================================
// Module      : mips_imem_pkg
// Description : Shared types and constants for the instruction memory and
//               its program loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_imem_pkg;

    // Loader states: idle after reset, streaming words, program complete
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } imem_state_t;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

endpackage : mips_imem_pkg

`default_nettype wire

// File: rtl/mips_imem_loader.sv
// ============================================================================
// Module      : mips_imem_loader
// Description : Program loader for the instruction memory. Owns the
//               IDLE/LOAD/DONE state machine, the word pointer, the
//               valid/ready handshake and the array write strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_imem_loader
    import mips_imem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             load_start,
    input  logic             load_valid,
    input  logic             load_last,
    output logic             load_ready,
    output logic             loading,
    output logic             load_done,
    output logic             wr_en,
    output logic [PTR_W-1:0] wr_ptr
);

    imem_state_t      r_state;
    imem_state_t      w_state_nxt;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic             w_accept;

    // State and pointer registers; reset overrides the advance enable
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
        end else if (clk_enable) begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next-state logic; load_start always restarts at word 0 and suppresses
    // any coincident write
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (load_start) begin
                    w_state_nxt = LOAD;
                    w_ptr_nxt   = '0;
                end
            end
            LOAD: begin
                if (load_start) begin
                    w_ptr_nxt = '0;
                end else if (load_valid) begin
                    w_accept  = 1'b1;
                    w_ptr_nxt = r_ptr + PTR_W'(1);
                    if (load_last || (r_ptr == PTR_W'(DEPTH - 1))) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (load_start) begin
                    w_state_nxt = LOAD;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    assign load_ready = (r_state == LOAD);
    assign loading    = (r_state == LOAD);
    assign load_done  = (r_state == DONE);
    assign wr_en      = w_accept & clk_enable & ~reset;
    assign wr_ptr     = r_ptr;

endmodule : mips_imem_loader

`default_nettype wire

// File: rtl/mips_cpu_instr_memory.sv
// ============================================================================
// Module      : mips_cpu_instr_memory
// Description : Instruction-side memory for the Harvard MIPS CPU. Same-cycle
//               combinational fetch, handshaked program loader, sticky
//               fetch-fault flag for misaligned/out-of-range fetches.
//               Optional legal-fetch counter enabled by defining
//               MIPS_IMEM_FETCH_COUNT_EN; otherwise fetch_count reads 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_cpu_instr_memory
    import mips_imem_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = RESET_VECTOR,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic        load_start,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_done,
    output logic        loading,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic          r_fault;
    logic [31:0]   w_off;
    logic          w_legal;
    logic [AW-1:0] w_idx;
    logic          w_loading;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_ptr;
    logic          w_fault_evt;

    mips_imem_loader #(
        .DEPTH (DEPTH),
        .PTR_W (AW)
    ) u_loader (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_last  (load_last),
        .load_ready (load_ready),
        .loading    (w_loading),
        .load_done  (load_done),
        .wr_en      (w_wr_en),
        .wr_ptr     (w_wr_ptr)
    );

    // Byte offset from the reset vector decides legality and word index
    assign w_off   = instr_address - BASE_ADDR;
    assign w_legal = (w_off[1:0] == 2'b00) && (w_off[31:2] < 30'(DEPTH));
    assign w_idx   = w_off[AW+1:2];

    // The halt address is the CPU's "stopped" signal, never an error
    assign w_fault_evt = !w_loading && (instr_address != HALT_ADDR) && !w_legal;

    assign instr_readdata = (w_legal && !w_loading) ? r_mem[w_idx] : NOP_WORD;
    assign loading        = w_loading;
    assign fetch_fault    = r_fault;

    // Program array write port; contents survive reset
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_ptr] <= load_data;
        end
    end

    // Sticky fault flag, cleared by reset or a new program load
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if (clk_enable) begin
            if (load_start) begin
                r_fault <= 1'b0;
            end else if (w_fault_evt) begin
                r_fault <= 1'b1;
            end
        end
    end

`ifdef MIPS_IMEM_FETCH_COUNT_EN
    logic [31:0] r_fetch_count;

    // Saturating count of legal fetches outside of program loads
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count <= '0;
        end else if (clk_enable) begin
            if (load_start) begin
                r_fetch_count <= '0;
            end else if (!w_loading && w_legal && (r_fetch_count != 32'hFFFF_FFFF)) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign fetch_count = r_fetch_count;
`else
    assign fetch_count = 32'h0;
`endif

endmodule : mips_cpu_instr_memory

`default_nettype wire
